// File: rtl/dmem_sram_bridge_pkg.sv
// Shared definitions for the pipeline-to-SRAM-bus bridges (data side and instruction side).
// Holds the FSM state encoding, the bus size codes and a small strobe helper.
package dmem_sram_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } bridge_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Any active byte strobe marks the access as a store.
   function automatic logic is_write(input logic [3:0] wen);
      return |wen;
   endfunction

endpackage

// File: rtl/dmem_sram_bridge.sv
// M-stage data bridge: turns one load/store into a req/addr_ok/data_ok bus transaction,
// stalls the pipeline until it completes and holds the load result while the pipe is frozen.
module dmem_sram_bridge
   import dmem_sram_bridge_pkg::*;
#(
   parameter int TIMEOUT_W   = 8,
   parameter int TIMEOUT_MAX = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_en,
   input  logic [3:0]           mem_wen,
   input  logic [1:0]           mem_size,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wdata,
   input  logic                 pipe_hold,
   output logic [31:0]          mem_rdata,
   output logic                 mem_stall,
   output logic                 bus_err,
   output logic                 data_req,
   output logic                 data_wr,
   output logic [1:0]           data_size,
   output logic [31:0]          data_addr,
   output logic [3:0]           data_wstrb,
   output logic [31:0]          data_wdata,
   input  logic                 data_addr_ok,
   input  logic                 data_data_ok,
   input  logic [31:0]          data_rdata,
   output logic [1:0]           dbg_state,
   output logic [TIMEOUT_W-1:0] dbg_wdog
);

   // Bus handshake: a request is offered while data_req = 1 and is taken on the
   // cycle data_addr_ok = 1; the response is the single cycle data_data_ok = 1,
   // always strictly after the accepting cycle.

   localparam logic [TIMEOUT_W-1:0] WDOG_MAX = TIMEOUT_W'(TIMEOUT_MAX);

   bridge_state_e        state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [3:0]           wen_q, wen_d;
   logic [1:0]           size_q, size_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 wr_q, wr_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic                 bus_err_q, bus_err_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      rdata_d   = rdata_q;
      wdog_d    = wdog_q;
      bus_err_d = bus_err_q;
      data_req  = 1'b0;
      mem_stall = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Gated by reset so every output reads 0 while reset is held.
            mem_stall = mem_en & rst;
            if (mem_en) begin
               addr_d  = mem_addr;
               wen_d   = mem_wen;
               size_d  = mem_size;
               wdata_d = mem_wdata;
               wr_d    = is_write(mem_wen);
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            data_req  = 1'b1;
            mem_stall = 1'b1;
            if (data_addr_ok) state_d = ST_DATA;
         end
         ST_DATA: begin
            mem_stall = 1'b1;
            if (data_data_ok) begin
               if (!wr_q) rdata_d = data_rdata;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!pipe_hold) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Watchdog counts bus wait cycles, saturating; the error flag is sticky.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         wdog_d = '0;
      end else if ((state_q == ST_REQ || state_q == ST_DATA) && wdog_q != WDOG_MAX) begin
         wdog_d = wdog_q + 1'b1;
      end
      if (wdog_d == WDOG_MAX) bus_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wen_q     <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rdata_q   <= '0;
         wdog_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         rdata_q   <= rdata_d;
         wdog_q    <= wdog_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign mem_rdata  = rdata_q;
   assign bus_err    = bus_err_q;
   assign data_wr    = wr_q;
   assign data_size  = size_q;
   assign data_addr  = addr_q;
   assign data_wstrb = wen_q;
   assign data_wdata = wdata_q;
   assign dbg_state  = state_q;
   assign dbg_wdog   = wdog_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios plus randomized
// back-to-back accesses against a per-transaction timeline model.
module tb_dmem_sram_bridge;
   import dmem_sram_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en = 1'b0;
   logic [3:0]  mem_wen = '0;
   logic [1:0]  mem_size = '0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        pipe_hold = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        bus_err;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic [1:0]  dbg_state;
   logic [7:0]  dbg_wdog;

   int errors = 0;
   int checks = 0;

   // Reference state: last load value seen by the pipeline and the sticky error.
   logic [31:0] model_rdata = '0;
   logic        model_err = 1'b0;

   dmem_sram_bridge #(.TIMEOUT_W(8), .TIMEOUT_MAX(255)) dut (
      .clk(clk), .rst(rst),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pipe_hold(pipe_hold),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_err(bus_err),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .dbg_state(dbg_state), .dbg_wdog(dbg_wdog)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [3:0] strobes_for(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] s;
      case (sz)
         SZ_B:    s = 4'b0001 << a[1:0];
         SZ_H:    s = a[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // One whole access: IDLE, a+1 REQ cycles, d DATA cycles, hold+1 DONE cycles.
   // Entered and left at a falling edge.
   task automatic run_access(input string name, input logic [3:0] wen, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int a, input int d, input int hold);
      int n_req, total, done_from, wd_exp;
      logic is_ld, in_req, in_data, in_done;
      logic [31:0] rd_before, rd_after, rd_exp;
      logic [1:0] st_exp;
      n_req     = a + 1;
      done_from = 1 + n_req + d;
      total     = done_from + hold + 1;
      is_ld     = (wen == 4'b0000);
      rd_before = model_rdata;
      rd_after  = is_ld ? rdata : model_rdata;
      for (int k = 0; k < total; k++) begin
         in_req  = (k >= 1) && (k <= n_req);
         in_data = (k > n_req) && (k < done_from);
         in_done = (k >= done_from);
         mem_en = 1'b1;
         if (k == 0) begin
            mem_wen = wen; mem_size = size; mem_addr = addr; mem_wdata = wdata;
         end else begin
            mem_wen = 4'($urandom); mem_size = 2'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
         end
         pipe_hold    = in_done ? (k < total - 1) : 1'($urandom_range(0, 1));
         data_addr_ok = (k == n_req);
         data_data_ok = (k == done_from - 1) ||
                        ((k == 0 || k == n_req) && $urandom_range(0, 1) == 1);
         data_rdata   = (k == done_from - 1) ? rdata : $urandom;
         #2;
         st_exp = in_done ? ST_DONE : in_data ? ST_DATA : in_req ? ST_REQ : ST_IDLE;
         rd_exp = in_done ? rd_after : rd_before;
         wd_exp = (in_req || in_data) ? k - 1 : 0;
         checks++;
         if ({mem_stall, data_req, bus_err} !== {~in_done, in_req, model_err}) begin
            errors++;
            $display("FAIL %s ctrl k=%0d: stall/req/err got %b%b%b expected %b%b%b", name, k,
                     mem_stall, data_req, bus_err, ~in_done, in_req, model_err);
         end
         checks++;
         if (dbg_state !== st_exp) begin
            errors++;
            $display("FAIL %s state k=%0d: got %0d expected %0d", name, k, dbg_state, st_exp);
         end
         checks++;
         if (mem_rdata !== rd_exp) begin
            errors++;
            $display("FAIL %s rdata k=%0d: got %h expected %h", name, k, mem_rdata, rd_exp);
         end
         checks++;
         if (dbg_wdog !== 8'(wd_exp)) begin
            errors++;
            $display("FAIL %s wdog k=%0d: got %0d expected %0d", name, k, dbg_wdog, wd_exp);
         end
         if (in_req) begin
            checks++;
            if ({data_wr, data_size, data_addr, data_wstrb, data_wdata} !==
                {~is_ld, size, addr, wen, wdata}) begin
               errors++;
               $display("FAIL %s bus k=%0d: wr=%b sz=%0d addr=%h strb=%b wd=%h expected wr=%b sz=%0d addr=%h strb=%b wd=%h",
                        name, k, data_wr, data_size, data_addr, data_wstrb, data_wdata,
                        ~is_ld, size, addr, wen, wdata);
            end
         end
         @(negedge clk);
      end
      model_rdata  = rd_after;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      pipe_hold    = 1'b0;
   endtask

   task automatic idle_cycle(input string name);
      mem_en = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      #2;
      checks++;
      if ({dbg_state, mem_stall, data_req, mem_rdata} !== {ST_IDLE, 1'b0, 1'b0, model_rdata}) begin
         errors++;
         $display("FAIL %s idle: state=%0d stall=%b req=%b rdata=%h expected 0 0 0 %h",
                  name, dbg_state, mem_stall, data_req, mem_rdata, model_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_en = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if ({mem_rdata, mem_stall, bus_err, data_req, data_wr, data_size, data_addr,
           data_wstrb, data_wdata, dbg_state, dbg_wdog} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdata=%h stall=%b err=%b req=%b wr=%b addr=%h state=%0d expected all 0",
                  mem_rdata, mem_stall, bus_err, data_req, data_wr, data_addr, dbg_state);
      end
      @(negedge clk);
      mem_en = 1'b0;
      rst = 1'b1;
      model_rdata = '0;
      model_err = 1'b0;
      idle_cycle("reset_release");
   endtask

   task automatic test_load_zero_wait();
      run_access("load_zero_wait", 4'b0000, SZ_W, 32'h1000_0004, 32'h0, 32'hDEADBEEF, 0, 1, 0);
   endtask

   task automatic test_store_byte();
      run_access("store_byte", 4'b0100, SZ_B, 32'h1000_0002, 32'h00AB_0000, $urandom, 0, 1, 0);
   endtask

   task automatic test_slow_bus();
      run_access("slow_bus", 4'b0000, SZ_W, 32'h2000_0010, 32'h0, 32'hCAFE_F00D, 3, 5, 0);
   endtask

   task automatic test_pipe_hold();
      run_access("pipe_hold", 4'b0000, SZ_H, 32'h1000_0006, 32'h0, 32'h1234_5678, 0, 1, 4);
      idle_cycle("pipe_hold_after");
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sz;
      logic [31:0] a;
      logic [3:0]  w;
      for (int i = 0; i < 24; i++) begin
         sz = 2'($urandom_range(0, 2));
         a  = $urandom;
         w  = ($urandom_range(0, 1) == 1) ? strobes_for(sz, a) : 4'b0000;
         run_access("back_to_back", w, sz, a, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(0, 3));
      end
      idle_cycle("back_to_back_end");
   endtask

   task automatic test_reset_mid();
      mem_en = 1'b1; mem_wen = 4'b0000; mem_size = SZ_W; mem_addr = 32'h3000_0000;
      @(negedge clk);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      #2;
      checks++;
      if (dbg_state !== ST_DATA) begin
         errors++;
         $display("FAIL reset_mid_setup: state got %0d expected %0d", dbg_state, ST_DATA);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({mem_rdata, mem_stall, bus_err, data_req, data_wr, data_addr, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: rdata=%h stall=%b req=%b addr=%h state=%0d expected all 0",
                  mem_rdata, mem_stall, data_req, data_addr, dbg_state);
      end
      model_rdata = '0;
      model_err = 1'b0;
      mem_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      data_data_ok = 1'b1;
      data_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      data_data_ok = 1'b0;
      idle_cycle("reset_mid_stale_ok");
   endtask

   task automatic test_watchdog();
      int wd_exp;
      logic err_exp;
      mem_en = 1'b1; mem_wen = 4'b0000; mem_size = SZ_W; mem_addr = 32'h4000_0000;
      data_addr_ok = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 300; k++) begin
         mem_addr = $urandom;
         #2;
         wd_exp  = (k - 1 > 255) ? 255 : k - 1;
         err_exp = (wd_exp == 255);
         checks++;
         if ({data_req, mem_stall, bus_err, dbg_wdog} !== {1'b1, 1'b1, err_exp, 8'(wd_exp)}) begin
            errors++;
            $display("FAIL watchdog k=%0d: req=%b stall=%b err=%b wdog=%0d expected 1 1 %b %0d",
                     k, data_req, mem_stall, bus_err, dbg_wdog, err_exp, wd_exp);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      mem_en = 1'b0;
      #1;
      checks++;
      if ({bus_err, dbg_wdog} !== '0) begin
         errors++;
         $display("FAIL watchdog_reset: err=%b wdog=%0d expected 0 0", bus_err, dbg_wdog);
      end
      model_rdata = '0;
      model_err = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle_cycle("watchdog_after_reset");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_load_zero_wait();
      test_store_byte();
      test_slow_bus();
      test_pipe_hold();
      test_back_to_back();
      test_reset_mid();
      test_load_zero_wait();
      test_watchdog();
      test_store_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
